// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: merges the WB-stage write-back with a
// 2-entry buffer of long-latency results, with a starvation limit on the buffer.
module rf_wr_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        ws_req_valid,
  input  logic [3:0]  ws_req_we,
  input  logic [4:0]  ws_req_dest,
  input  logic [31:0] ws_req_wdata,
  output logic        ws_req_ready,

  input  logic        lu_req_valid,
  input  logic [3:0]  lu_req_we,
  input  logic [4:0]  lu_req_dest,
  input  logic [31:0] lu_req_wdata,
  output logic        lu_req_ready,

  output logic [3:0]  rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,

  output logic [11:0] stall_lu_bus,
  output logic        grant_lu
);

  typedef struct packed {
    logic [3:0]  we;
    logic [4:0]  dest;
    logic [31:0] wdata;
  } wb_req_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  wb_req_t    ent0, ent1;
  logic [1:0] ent_valid;
  logic [3:0] starve_cnt;

  wb_req_t    lu_in;
  logic       occ0, occ1;
  logic [1:0] count;
  logic       lu_take;
  logic       force_lu;
  logic       grant_ws;

  assign lu_in = '{we: lu_req_we, dest: lu_req_dest, wdata: lu_req_wdata};

  // Occupancy is masked by reset so every output is already in its idle
  // state during the reset cycle, before the registers have been cleared.
  assign occ0  = ent_valid[0] & ~reset;
  assign occ1  = ent_valid[1] & ~reset;
  assign count = {1'b0, occ0} + {1'b0, occ1};

  assign lu_req_ready = (count != 2'd2);
  assign lu_take      = lu_req_valid && lu_req_ready && (lu_req_we != 4'd0) && !reset;

  assign force_lu     = (count != 2'd0) && (starve_cnt == LIMIT);
  assign grant_lu     = (count != 2'd0) && (force_lu || !ws_req_valid);
  assign grant_ws     = ws_req_valid && !force_lu && !reset;
  assign ws_req_ready = !force_lu;

  assign stall_lu_bus = {occ1, occ1 ? ent1.dest : 5'd0,
                         occ0, occ0 ? ent0.dest : 5'd0};

  // NOTE: every output of a combinational block gets a default before the
  // if/else; a path that leaves one unassigned would infer a latch.
  always_comb begin
    rf_we    = 4'd0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (grant_lu) begin
      rf_we    = ent0.we;
      rf_waddr = ent0.dest;
      rf_wdata = ent0.wdata;
    end else if (grant_ws) begin
      rf_we    = ws_req_we;
      rf_waddr = ws_req_dest;
      rf_wdata = ws_req_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid <= 2'b00;
    end else if (grant_lu && lu_take) begin
      ent_valid <= 2'b01;
    end else if (grant_lu) begin
      ent_valid <= {1'b0, ent_valid[1]};
    end else if (lu_take) begin
      ent_valid <= ent_valid[0] ? 2'b11 : 2'b01;
    end
  end

  // NOTE: the payload registers are not reset; the valid bits alone decide
  // whether an entry is meaningful, so clearing data would only cost logic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (grant_lu && lu_take) begin
        ent0 <= lu_in;
      end else if (grant_lu) begin
        ent0 <= ent1;
      end else if (lu_take) begin
        if (ent_valid[0]) ent1 <= lu_in;
        else              ent0 <= lu_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (grant_lu || count == 2'd0) begin
      starve_cnt <= 4'd0;
    end else if (grant_ws && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule
